// File: rtl/alu_mc_pkg.sv
// Shared types for alu_mc: opcode and FSM state enums plus the legal-opcode map.
// Build option: define ALU_MC_MUL_EN to make opcode 1100 (MUL) legal.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_XOR   = 4'h1,
    OP_BNEZ  = 4'h2,
    OP_ADD   = 4'h3,
    OP_LSH   = 4'h4,
    OP_RSH   = 4'h5,
    OP_PASSB = 4'h6,
    OP_PASSA = 4'h7,
    OP_PARI  = 4'h8,
    OP_ADC   = 4'h9,
    OP_OR    = 4'hA,
    OP_SUB   = 4'hB,
    OP_MUL   = 4'hC,
    OP_AND   = 4'hD,
    OP_ILL0  = 4'hE,
    OP_ILL1  = 4'hF
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit n set means opcode n is legal in this build.
`ifdef ALU_MC_MUL_EN
  localparam logic [15:0] OP_LEGAL = 16'h3FFF;
`else
  localparam logic [15:0] OP_LEGAL = 16'h2FFF;
`endif

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bus of alu_mc. Build option ALU_MC_MUL_EN does not change this bus.
interface alu_mc_if #(parameter int W = 8);

  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_cmd;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         sc_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] rslt;
  logic         sc_o;
  logic         pari;
  logic         zero;
  logic         err;

  // Both channels are valid/ready: a transfer happens on a rising edge where
  // valid && ready; the sender holds its payload stable while valid && !ready.
  modport master (
    output in_valid, alu_cmd, inA, inB, sc_i, out_ready,
    input  in_ready, out_valid, rslt, sc_o, pari, zero, err
  );

  modport slave (
    input  in_valid, alu_cmd, inA, inB, sc_i, out_ready,
    output in_ready, out_valid, rslt, sc_o, pari, zero, err
  );

endinterface

// File: rtl/alu_mc_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, W cycles.
// Only instantiated when ALU_MC_MUL_EN is defined.
module alu_mc_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc_next;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  // The last iteration is folded into product so the caller can latch it on done.
  assign done     = (cnt == CW'(1));
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(W);
    end else if (cnt != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready request and result channels.
// Build option: ALU_MC_MUL_EN adds the iterative MUL opcode and the BUSY state.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W) + 1
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus,
  output state_t   state_dbg
);

  state_t         state;
  state_t         state_nx;
  op_t            op;
  logic           accept;
  logic           cmd_mul;
  logic           cmd_legal;
  logic           mul_done;
  logic [2*W-1:0] mul_prod;
  logic [SHW-1:0] amt;
  logic [W:0]     sum;
  logic [W-1:0]   alu_r;
  logic           alu_c;
  logic [W-1:0]   rslt_q;
  logic           sc_q;
  logic           err_q;

  assign op        = op_t'(bus.alu_cmd);
  assign cmd_legal = OP_LEGAL[bus.alu_cmd];
  assign amt       = bus.inA[SHW-1:0];
  assign accept    = bus.in_valid && bus.in_ready;

`ifdef ALU_MC_MUL_EN
  assign cmd_mul = (op == OP_MUL);

  alu_mc_mul #(.W(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && cmd_mul),
    .a       (bus.inA),
    .b       (bus.inB),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign cmd_mul  = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Single-cycle datapath; MUL, NOP and illegal opcodes fall through to zero.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    sum   = '0;
    case (op)
      OP_XOR:   alu_r = bus.inA ^ bus.inB;
      OP_BNEZ:  alu_r = W'(bus.inB != '0);
      OP_ADD: begin
        sum            = {1'b0, bus.inA} + {1'b0, bus.inB};
        {alu_c, alu_r} = sum;
      end
      OP_ADC: begin
        sum            = {1'b0, bus.inA} + {1'b0, bus.inB} + {{W{1'b0}}, bus.sc_i};
        {alu_c, alu_r} = sum;
      end
      OP_SUB: begin
        sum            = {1'b0, bus.inB} - {1'b0, bus.inA};
        {alu_c, alu_r} = sum;
      end
      OP_LSH:   alu_r = (32'(amt) >= W) ? '0 : (bus.inB << amt);
      OP_RSH:   alu_r = (32'(amt) >= W) ? '0 : (bus.inB >> amt);
      OP_PASSB: alu_r = bus.inB;
      OP_PASSA: alu_r = bus.inA;
      OP_PARI:  alu_r = W'(^bus.inA);
      OP_OR:    alu_r = bus.inA | bus.inB;
      OP_AND:   alu_r = bus.inA & bus.inB;
      default:  alu_r = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = cmd_mul ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mul_done) state_nx = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nx = accept ? (cmd_mul ? ST_BUSY : ST_DONE) : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rslt_q <= '0;
      sc_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && !cmd_mul) begin
        rslt_q <= alu_r;
        sc_q   <= alu_c;
        err_q  <= !cmd_legal;
      end else if ((state == ST_BUSY) && mul_done) begin
        rslt_q <= mul_prod[W-1:0];
        sc_q   <= |mul_prod[2*W-1:W];
        err_q  <= 1'b0;
      end
    end
  end

  // Result fields come straight from registers so they hold under backpressure.
  assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.rslt      = rslt_q;
  assign bus.sc_o      = sc_q;
  assign bus.err       = err_q;
  assign bus.zero      = (rslt_q == '0);
  assign bus.pari      = ^rslt_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (W=8); covers both builds of ALU_MC_MUL_EN.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   reset;
  state_t state_dbg;
  int     total;
  int     bad;

  typedef struct {
    logic [3:0]   cmd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] r;
    logic         c;
    logic         e;
  } vec_t;

  vec_t vecs[$];

  alu_mc_if #(.W(W)) bus ();

  alu_mc #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci);
    bus.in_valid = 1'b1;
    bus.alu_cmd  = cmd;
    bus.inA      = a;
    bus.inB      = b;
    bus.sc_i     = ci;
  endtask

  task automatic scramble();
    bus.in_valid = 1'b0;
    bus.alu_cmd  = 4'($urandom_range(0, 15));
    bus.inA      = W'($urandom_range(0, 255));
    bus.inB      = W'($urandom_range(0, 255));
    bus.sc_i     = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    drive(4'h3, 8'h01, 8'h01, 1'b0);
    repeat (3) step();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.rslt !== 8'h00) begin bad++; $display("FAIL rst rslt: got %h want 00", bus.rslt); end
    total++; if (bus.sc_o !== 1'b0) begin bad++; $display("FAIL rst sc_o: got %b want 0", bus.sc_o); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst err: got %b want 0", bus.err); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL rst zero: got %b want 1", bus.zero); end
    total++; if (bus.pari !== 1'b0) begin bad++; $display("FAIL rst pari: got %b want 0", bus.pari); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL rst state: got %0d want %0d", state_dbg, ST_IDLE); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst ignore_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_ops();
    vecs.delete();
    vecs.push_back('{4'h3, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0});
    vecs.push_back('{4'h3, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0});
    vecs.push_back('{4'h9, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{4'h9, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0});
    vecs.push_back('{4'hB, 8'h05, 8'h03, 1'b0, 8'hFE, 1'b1, 1'b0});
    vecs.push_back('{4'hB, 8'h03, 8'h05, 1'b0, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{4'h1, 8'h5A, 8'h0F, 1'b0, 8'h55, 1'b0, 1'b0});
    vecs.push_back('{4'h2, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{4'h2, 8'h00, 8'h04, 1'b0, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{4'h4, 8'h08, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{4'h4, 8'h03, 8'h81, 1'b0, 8'h08, 1'b0, 1'b0});
    vecs.push_back('{4'h4, 8'h11, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{4'h5, 8'h04, 8'hF0, 1'b0, 8'h0F, 1'b0, 1'b0});
    vecs.push_back('{4'h5, 8'h09, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{4'h5, 8'h07, 8'h80, 1'b0, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{4'h6, 8'h12, 8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0});
    vecs.push_back('{4'h7, 8'h3C, 8'h12, 1'b0, 8'h3C, 1'b0, 1'b0});
    vecs.push_back('{4'h8, 8'h07, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{4'h8, 8'h03, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{4'hA, 8'hA0, 8'h05, 1'b0, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{4'hD, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0});
    vecs.push_back('{4'h0, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{4'hE, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{4'hF, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1});
    foreach (vecs[i]) begin
      drive(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].ci);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL op%0d in_ready: got %b want 1", i, bus.in_ready); end
      step();
      scramble();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL op%0d out_valid: got %b want 1", i, bus.out_valid); end
      total++; if (bus.rslt !== vecs[i].r) begin bad++; $display("FAIL op%0d rslt: got %h want %h", i, bus.rslt, vecs[i].r); end
      total++; if (bus.sc_o !== vecs[i].c) begin bad++; $display("FAIL op%0d sc_o: got %b want %b", i, bus.sc_o, vecs[i].c); end
      total++; if (bus.err !== vecs[i].e) begin bad++; $display("FAIL op%0d err: got %b want %b", i, bus.err, vecs[i].e); end
      total++; if (bus.zero !== (vecs[i].r == 8'h00)) begin bad++; $display("FAIL op%0d zero: got %b want %b", i, bus.zero, (vecs[i].r == 8'h00)); end
      total++; if (bus.pari !== (^vecs[i].r)) begin bad++; $display("FAIL op%0d pari: got %b want %b", i, bus.pari, ^vecs[i].r); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   cmds[4] = '{4'h3, 4'h1, 4'hB, 4'h7};
    logic [W-1:0] as[4]   = '{8'h01, 8'hFF, 8'hA1, 8'h77};
    logic [W-1:0] bs[4]   = '{8'h02, 8'h0F, 8'hA1, 8'h00};
    logic [W-1:0] rs[4]   = '{8'h03, 8'hF0, 8'h00, 8'h77};
    for (int i = 0; i < 4; i++) begin
      drive(cmds[i], as[i], bs[i], 1'b0);
      step();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d out_valid: got %b want 1", i, bus.out_valid); end
      total++; if (bus.rslt !== rs[i]) begin bad++; $display("FAIL b2b%0d rslt: got %h want %h", i, bus.rslt, rs[i]); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d in_ready: got %b want 1", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(4'h1, 8'h0F, 8'hF0, 1'b0);
    step();
    drive(4'h3, 8'h01, 8'h02, 1'b0);
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp%0d out_valid: got %b want 1", k, bus.out_valid); end
      total++; if (bus.rslt !== 8'hFF) begin bad++; $display("FAIL bp%0d rslt: got %h want ff", k, bus.rslt); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp%0d in_ready: got %b want 0", k, bus.in_ready); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp release in_ready: got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp next out_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.rslt !== 8'h03) begin bad++; $display("FAIL bp next rslt: got %h want 03", bus.rslt); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_mul();
`ifdef ALU_MC_MUL_EN
    logic [W-1:0] ma[3] = '{8'h10, 8'h0F, 8'hFF};
    logic [W-1:0] mb[3] = '{8'h11, 8'h0F, 8'hFF};
    logic [W-1:0] mr[3] = '{8'h10, 8'hE1, 8'h01};
    logic         mc[3] = '{1'b1, 1'b0, 1'b1};
    // The first MUL is issued from DONE to cover the DONE->BUSY path.
    drive(4'h3, 8'h02, 8'h02, 1'b0);
    step();
    total++; if (bus.rslt !== 8'h04) begin bad++; $display("FAIL mul pre rslt: got %h want 04", bus.rslt); end
    for (int i = 0; i < 3; i++) begin
      drive(4'hC, ma[i], mb[i], 1'b0);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mul%0d in_ready: got %b want 1", i, bus.in_ready); end
      step();
      scramble();
      for (int k = 1; k <= W; k++) begin
        total++; if ({bus.out_valid, bus.in_ready} !== 2'b00) begin bad++; $display("FAIL mul%0d busy cyc%0d: got %b want 00", i, k, {bus.out_valid, bus.in_ready}); end
        step();
      end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mul%0d out_valid: got %b want 1", i, bus.out_valid); end
      total++; if (bus.rslt !== mr[i]) begin bad++; $display("FAIL mul%0d rslt: got %h want %h", i, bus.rslt, mr[i]); end
      total++; if (bus.sc_o !== mc[i]) begin bad++; $display("FAIL mul%0d sc_o: got %b want %b", i, bus.sc_o, mc[i]); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL mul%0d err: got %b want 0", i, bus.err); end
      step();
    end
`else
    drive(4'hC, 8'h10, 8'h11, 1'b0);
    step();
    scramble();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mul off out_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.rslt !== 8'h00) begin bad++; $display("FAIL mul off rslt: got %h want 00", bus.rslt); end
    total++; if (bus.sc_o !== 1'b0) begin bad++; $display("FAIL mul off sc_o: got %b want 0", bus.sc_o); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL mul off err: got %b want 1", bus.err); end
    step();
`endif
  endtask

  task automatic test_reset_abort();
`ifdef ALU_MC_MUL_EN
    drive(4'hC, 8'hFF, 8'hFF, 1'b0);
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort mul cyc%0d out_valid: got %b want 0", k, bus.out_valid); end
      step();
    end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL abort mul state: got %0d want %0d", state_dbg, ST_IDLE); end
    drive(4'h3, 8'h01, 8'h01, 1'b0);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.rslt !== 8'h02) begin bad++; $display("FAIL abort mul recover rslt: got %h want 02", bus.rslt); end
    step();
`endif
    bus.out_ready = 1'b0;
    drive(4'h7, 8'h5A, 8'h00, 1'b0);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL abort done pre out_valid: got %b want 1", bus.out_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort done out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.rslt !== 8'h00) begin bad++; $display("FAIL abort done rslt: got %h want 00", bus.rslt); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL abort done zero: got %b want 1", bus.zero); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort done after: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_cmd   = 4'h0;
    bus.inA       = '0;
    bus.inB       = '0;
    bus.sc_i      = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_mul();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter W, default 8, data-path width in bits (W >= 4).
REQ-002 Parameter SHW, default $clog2(W)+1, width of shift-amount field taken from inA[SHW-1:0].
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 alu_cmd  input  4  opcode.
REQ-009 inA, inB  input  W each  operands.
REQ-010 sc_i  input  1  carry in, used by ADC only.
REQ-011 out_valid  output  1  result held valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 rslt  output  W  result; sc_o output 1 carry/borrow/overflow; pari output 1 reduction XOR of rslt; zero output 1 rslt==0; err output 1 illegal/disabled opcode.

Function
REQ-014 Opcodes SHALL be: 0000 NOP (rslt 0), 0001 XOR, 0010 BNEZ (rslt 1 if inB!=0 else 0), 0011 ADD, 0100 LSH (inB<<amt), 0101 RSH (inB>>amt, logical), 0110 PASSB, 0111 PASSA, 1000 PARI (rslt = {W-1 zeros, ^inA}), 1001 ADC (inA+inB+sc_i), 1010 OR, 1011 SUB (inB-inA), 1100 MUL, 1101 AND; 1110/1111 illegal.
REQ-015 Operands, opcode and sc_i SHALL be captured on the cycle in_valid && in_ready; later input changes SHALL NOT affect the result.
REQ-016 FSM states IDLE, BUSY, DONE; IDLE->DONE on accept of non-MUL op; IDLE->BUSY on accept of MUL; BUSY->DONE after exactly W iteration cycles; DONE->IDLE on out_ready with no new accept; DONE->DONE/BUSY on out_ready with simultaneous accept.
REQ-017 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal to out_ready in DONE (back-to-back throughput of one op per cycle for non-MUL ops).
REQ-018 out_valid SHALL be 1 exactly in DONE; rslt/sc_o/pari/zero/err SHALL stay stable while out_valid && !out_ready.
REQ-019 Latency: non-MUL accept at cycle N -> out_valid at N+1; MUL accept at N -> out_valid at N+W+1.
REQ-020 Arithmetic modulo 2^W; sc_o = carry-out for ADD/ADC, borrow (inA>inB unsigned) for SUB, OR of upper W product bits for MUL, 0 for all others.
REQ-021 Shifts with amt >= W SHALL yield rslt 0.
REQ-022 MUL SHALL be unsigned iterative shift-add, rslt = low W bits of inA*inB.
REQ-023 Illegal opcode: rslt 0, sc_o 0, err 1, single-cycle latency; all legal opcodes err 0.
REQ-024 pari and zero SHALL be derived from registered rslt in all states.

Reset
REQ-025 reset SHALL force IDLE, in_ready 1 after release, out_valid 0, rslt 0, sc_o 0, err 0, zero 1, pari 0, and clear the multiplier iteration counter.
REQ-026 reset asserted in BUSY or DONE SHALL abort the operation; no out_valid for it SHALL appear.
REQ-027 in_valid during reset SHALL be ignored.

Configuration
REQ-028 Macro ALU_MC_MUL_EN defined: MUL per REQ-022; undefined: opcode 1100 treated as illegal per REQ-023, BUSY state and multiplier logic absent.

Structure
REQ-029 Package alu_mc_pkg SHALL hold the opcode enum, FSM state enum, and the opcode-to-legal mapping constant.
REQ-030 Iterative multiplier SHALL be sub-module alu_mc_mul (start, done, W-bit operands, 2W-bit product).

Verification
REQ-031 W=8: ADD 0xF0+0x20 -> rslt 0x10, sc_o 1, out_valid at N+1.
REQ-032 SUB inA=5 inB=3 -> rslt 0xFE, sc_o 1; ADC 0xFF+0x00+sc_i=1 -> rslt 0, zero 1, sc_o 1.
REQ-033 MUL 0x10*0x11 (macro on) -> rslt 0x10, sc_o 1 at N+9, in_ready 0 during BUSY; macro off -> rslt 0, err 1 at N+1.
REQ-034 out_ready held 0 for 5 cycles -> rslt stable, in_ready 0; then out_ready 1 with in_valid 1 -> new op accepted same cycle, result next cycle.
REQ-035 LSH inA=8 inB=0xFF -> rslt 0; opcode 1111 -> err 1; reset mid-MUL -> IDLE, no out_valid.
